maxpool_frame_ctrl: RTL

- Frame sequencer for the 2x2 binary max-pool line buffer in the binarized CNN path.
- Accepts a raster-ordered pixel stream with a valid/ready handshake and drives the pooling buffer's enable and clear.
- Tracks row and column position and flags each pooled result with its pooled coordinates under downstream backpressure.
- Signals frame completion to the layer scheduler.

---
 rtl/maxpool_frame_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/maxpool_frame_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : maxpool_frame_ctrl
// Function : Frame sequencer for the 2x2 binary max-pool line buffer; tracks
//            raster position and tags pooled outputs with their coordinates.
//            Optional abort input enabled by MAXPOOL_FRAME_CTRL_ABORT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module maxpool_frame_ctrl #(
    parameter int W  = 30,
    parameter int H  = 30,
    parameter int CW = 5,
    parameter int RW = 5
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iSTART,
    input  logic          iVALID,
`ifdef MAXPOOL_FRAME_CTRL_ABORT_EN
    input  logic          iABORT,
`endif
    output logic          oREADY,
    output logic          oEN,
    output logic          oCLR,
    output logic          oPOOL_VALID,
    input  logic          iOUT_READY,
    output logic [CW-1:0] oPCOL,
    output logic [RW-1:0] oPROW,
    output logic          oBUSY,
    output logic          oDONE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [CW-1:0] c_colLast = CW'(W - 1);
    localparam logic [RW-1:0] c_rowLast = RW'(H - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic            r_poolValid;
    logic [CW-1:0]   r_pcol;
    logic [RW-1:0]   r_prow;
    logic            w_abort;
    logic            w_ready;
    logic            w_accept;
    logic            w_lastPix;
    logic            w_poolSet;

`ifdef MAXPOOL_FRAME_CTRL_ABORT_EN
    assign w_abort = iABORT & (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // A slot is free when nothing is pending or the pending bit leaves this cycle
    assign w_ready   = (r_state == S_RUN) & ~w_abort & (~r_poolValid | iOUT_READY);
    assign w_accept  = iVALID & w_ready;
    assign w_lastPix = (r_col == c_colLast) & (r_row == c_rowLast);
    assign w_poolSet = w_accept & r_col[0] & r_row[0];

    assign oREADY      = w_ready;
    assign oEN         = w_accept;
    assign oPOOL_VALID = r_poolValid;
    assign oPCOL       = r_pcol;
    assign oPROW       = r_prow;
    assign oBUSY       = (r_state != S_IDLE);

    always_comb begin
        w_next = r_state;
        oCLR   = 1'b0;
        oDONE  = 1'b0;
        case (r_state)
            S_IDLE:  if (iSTART) w_next = S_CLEAR;
            S_CLEAR: begin
                oCLR   = 1'b1;
                w_next = S_RUN;
            end
            S_RUN:   if (w_accept && w_lastPix) w_next = S_DRAIN;
            // Leave as soon as the last pooled bit is gone or leaving this cycle
            S_DRAIN: if (!r_poolValid || iOUT_READY) w_next = S_DONE;
            S_DONE:  begin
                oDONE  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
            oCLR   = 1'b1;
            oDONE  = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_poolValid <= 1'b0;
            r_pcol      <= '0;
            r_prow      <= '0;
        end else begin
            r_state <= w_next;
            if (w_abort) begin
                r_col       <= '0;
                r_row       <= '0;
                r_poolValid <= 1'b0;
            end else begin
                if (r_state == S_CLEAR) begin
                    r_col <= '0;
                    r_row <= '0;
                end else if (w_accept) begin
                    if (r_col == c_colLast) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                // A new pooled result takes precedence over a simultaneous consume
                if (w_poolSet) begin
                    r_poolValid <= 1'b1;
                    r_pcol      <= {1'b0, r_col[CW-1:1]};
                    r_prow      <= {1'b0, r_row[RW-1:1]};
                end else if (r_poolValid && iOUT_READY) begin
                    r_poolValid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
